pass_tile_sequencer: RTL and testbench
======================================

Name: pass_tile_sequencer

Overview:
Top-level (L1) pass sequencer for the token engine. It walks a pass through its phases: weight load, FIFO/PE init, preheat and normal loop. It iterates over a configurable number of row tiles and reloads weights every N tiles. It adds per-phase watchdog timeouts and an abort path with a latched error code. It drives the L2 phase controllers through one-hot state outputs and receives their done pulses.

Parameters:
TILE_W, 8, width of tile count/index fields
TO_W, 16, width of watchdog timeout field

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
pass_start_i  in  1  start pulse; honoured only in IDLE
cfg_num_tiles_i  in  TILE_W  row tiles in this pass; sampled at accepted start
cfg_tiles_per_wgt_i  in  TILE_W  tiles per weight load; 0 = load once per pass; sampled at start
cfg_timeout_i  in  TO_W  watchdog limit in cycles; 0 = disabled; sampled at start
abort_i  in  1  abort request, level
weight_load_done_i  in  1  L2 weight-load done pulse
preheat_done_i  in  1  L2 preheat done pulse
normal_loop_done_i  in  1  L2 normal-loop done pulse
weight_load_state_o  out  1  high in INIT_WEIGHT
init_fifo_pe_state_o  out  1  high in INIT_FIFO_PE
preheat_state_o  out  1  high in PREHEAT
normal_loop_state_o  out  1  high in NORMAL_LOOP
tile_idx_o  out  TILE_W  current tile index, 0-based
pass_busy_o  out  1  high in any state except IDLE
pass_done_o  out  1  1-cycle pulse in PASS_DONE
pass_err_o  out  1  1-cycle pulse in PASS_ERR
err_code_o  out  2  0 abort, 1 weight timeout, 2 preheat timeout, 3 loop timeout

Behaviour:
- Reset: state IDLE; all outputs 0; tile_idx, wgt_cnt, watchdog counter and latched config all 0.
- States: IDLE, INIT_WEIGHT, INIT_FIFO_PE, PREHEAT, NORMAL_LOOP, PASS_DONE, PASS_ERR. The state outputs are registered-state decodes with no extra latency.
- IDLE, on pass_start_i:
  - latch all cfg_* inputs; clear tile_idx, wgt_cnt and err_code_o.
  - next state is INIT_WEIGHT, or PASS_DONE if cfg_num_tiles_i==0.
- INIT_WEIGHT: on weight_load_done_i, go to INIT_FIFO_PE.
- INIT_FIFO_PE: lasts exactly 1 cycle, then PREHEAT.
- PREHEAT: on preheat_done_i, go to NORMAL_LOOP.
- NORMAL_LOOP, on normal_loop_done_i:
  - if tile_idx==num_tiles-1, go to PASS_DONE.
  - otherwise increment tile_idx.
  - If tiles_per_wgt!=0 and wgt_cnt==tiles_per_wgt-1: clear wgt_cnt, go to INIT_WEIGHT.
  - Otherwise increment wgt_cnt, go to INIT_FIFO_PE.
- PASS_DONE and PASS_ERR last 1 cycle each, then return to IDLE.
- tile_idx_o holds its final value in IDLE until the next accepted start.
- Watchdog (timeout!=0), in INIT_WEIGHT, PREHEAT and NORMAL_LOOP only:
  - counter clears on every state entry and increments each cycle spent in that state.
  - if counter==timeout-1 and that state's done input is low, go to PASS_ERR with code 1, 2 or 3 respectively.
  - INIT_FIFO_PE is never timed.
- abort_i in any state other than IDLE, PASS_DONE or PASS_ERR: go to PASS_ERR with code 0.
- Priority, highest first: abort_i > phase done > timeout.
- err_code_o is written on entry to PASS_ERR and held until the next accepted start.
- Done inputs arriving outside their matching state are ignored.
- pass_start_i outside IDLE is ignored, and cfg_* changes mid-pass have no effect.
- rst_n asserted mid-pass returns immediately to reset values; no pass_done_o or pass_err_o pulse is produced.
- Counter widths:
  - tile_idx and wgt_cnt are TILE_W wide and never wrap, since they are bounded by num_tiles-1.
  - watchdog is TO_W wide.

Test Plan:
- tiles=1, per_wgt=0, timeout=0; start at cycle 0, each done asserted on the first cycle of its state -> states INIT_WEIGHT@1, INIT_FIFO_PE@2, PREHEAT@3, NORMAL_LOOP@4; pass_done_o pulse @5; IDLE @6.
- tiles=4, per_wgt=2 -> exactly 2 INIT_WEIGHT visits (before tiles 0 and 2) and 4 INIT_FIFO_PE visits; tile_idx_o steps 0,1,2,3; single pass_done_o.
- tiles=0 -> pass_done_o the cycle after start; no phase state output ever high; tile_idx_o=0.
- tiles=2, timeout=8, preheat_done_i never asserted -> PASS_ERR on the 8th PREHEAT cycle; pass_err_o pulse; err_code_o=2 held in IDLE.
- abort_i asserted in NORMAL_LOOP of tile 1, together with normal_loop_done_i -> PASS_ERR with err_code_o=0; no pass_done_o; tile_idx_o=1.
- timeout=5, weight_load_done_i asserted exactly on the 5th INIT_WEIGHT cycle -> proceeds to INIT_FIFO_PE with no error; a second pass_start_i pulse mid-pass is ignored.

Source files
------------

// File: rtl/pass_tile_sequencer.sv
// Top-level pass sequencer: walks weight load, FIFO/PE init, preheat and normal
// loop over a configurable number of row tiles, with per-phase watchdog and abort.
module pass_tile_sequencer #(
   parameter int unsigned TILE_W = 8,
   parameter int unsigned TO_W   = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              pass_start_i,
   input  logic [TILE_W-1:0] cfg_num_tiles_i,
   input  logic [TILE_W-1:0] cfg_tiles_per_wgt_i,
   input  logic [TO_W-1:0]   cfg_timeout_i,
   input  logic              abort_i,
   input  logic              weight_load_done_i,
   input  logic              preheat_done_i,
   input  logic              normal_loop_done_i,
   output logic              weight_load_state_o,
   output logic              init_fifo_pe_state_o,
   output logic              preheat_state_o,
   output logic              normal_loop_state_o,
   output logic [TILE_W-1:0] tile_idx_o,
   output logic              pass_busy_o,
   output logic              pass_done_o,
   output logic              pass_err_o,
   output logic [1:0]        err_code_o
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WEIGHT,
      S_FIFO_PE,
      S_PREHEAT,
      S_LOOP,
      S_DONE,
      S_ERR
   } state_e;

   state_e            state_q, state_d;
   logic [TILE_W-1:0] tile_idx_q, tile_idx_d;
   logic [TILE_W-1:0] wgt_cnt_q, wgt_cnt_d;
   logic [TILE_W-1:0] num_tiles_q, num_tiles_d;
   logic [TILE_W-1:0] tiles_per_wgt_q, tiles_per_wgt_d;
   logic [TO_W-1:0]   timeout_q, timeout_d;
   logic [TO_W-1:0]   wdog_q, wdog_d;
   logic [1:0]        err_code_q, err_code_d;
   logic              weight_load_state_q, weight_load_state_d;
   logic              init_fifo_pe_state_q, init_fifo_pe_state_d;
   logic              preheat_state_q, preheat_state_d;
   logic              normal_loop_state_q, normal_loop_state_d;
   logic              pass_busy_q, pass_busy_d;
   logic              pass_done_q, pass_done_d;
   logic              pass_err_q, pass_err_d;

   logic              wdog_hit;
   logic              last_tile;
   logic              wgt_reload;
   logic              timed;

   // Next-state, counters and registered output decodes
   always_comb begin
      state_d         = state_q;
      tile_idx_d      = tile_idx_q;
      wgt_cnt_d       = wgt_cnt_q;
      num_tiles_d     = num_tiles_q;
      tiles_per_wgt_d = tiles_per_wgt_q;
      timeout_d       = timeout_q;
      err_code_d      = err_code_q;

      wdog_hit   = (timeout_q != '0) && (wdog_q == timeout_q - TO_W'(1));
      last_tile  = (tile_idx_q == num_tiles_q - TILE_W'(1));
      wgt_reload = (tiles_per_wgt_q != '0) && (wgt_cnt_q == tiles_per_wgt_q - TILE_W'(1));

      case (state_q)
         S_IDLE: begin
            if (pass_start_i) begin
               num_tiles_d     = cfg_num_tiles_i;
               tiles_per_wgt_d = cfg_tiles_per_wgt_i;
               timeout_d       = cfg_timeout_i;
               tile_idx_d      = '0;
               wgt_cnt_d       = '0;
               err_code_d      = 2'd0;
               state_d         = (cfg_num_tiles_i == '0) ? S_DONE : S_WEIGHT;
            end
         end
         S_WEIGHT: begin
            if (abort_i) begin
               state_d    = S_ERR;
               err_code_d = 2'd0;
            end else if (weight_load_done_i) begin
               state_d = S_FIFO_PE;
            end else if (wdog_hit) begin
               state_d    = S_ERR;
               err_code_d = 2'd1;
            end
         end
         S_FIFO_PE: begin
            if (abort_i) begin
               state_d    = S_ERR;
               err_code_d = 2'd0;
            end else begin
               state_d = S_PREHEAT;
            end
         end
         S_PREHEAT: begin
            if (abort_i) begin
               state_d    = S_ERR;
               err_code_d = 2'd0;
            end else if (preheat_done_i) begin
               state_d = S_LOOP;
            end else if (wdog_hit) begin
               state_d    = S_ERR;
               err_code_d = 2'd2;
            end
         end
         S_LOOP: begin
            if (abort_i) begin
               state_d    = S_ERR;
               err_code_d = 2'd0;
            end else if (normal_loop_done_i) begin
               if (last_tile) begin
                  state_d = S_DONE;
               end else begin
                  tile_idx_d = tile_idx_q + TILE_W'(1);
                  if (wgt_reload) begin
                     wgt_cnt_d = '0;
                     state_d   = S_WEIGHT;
                  end else begin
                     wgt_cnt_d = wgt_cnt_q + TILE_W'(1);
                     state_d   = S_FIFO_PE;
                  end
               end
            end else if (wdog_hit) begin
               state_d    = S_ERR;
               err_code_d = 2'd3;
            end
         end
         S_DONE:  state_d = S_IDLE;
         S_ERR:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // Watchdog restarts on every state entry and only runs in timed phases
      timed  = (state_q == S_WEIGHT) || (state_q == S_PREHEAT) || (state_q == S_LOOP);
      wdog_d = (timed && (state_d == state_q)) ? wdog_q + TO_W'(1) : '0;

      weight_load_state_d  = (state_d == S_WEIGHT);
      init_fifo_pe_state_d = (state_d == S_FIFO_PE);
      preheat_state_d      = (state_d == S_PREHEAT);
      normal_loop_state_d  = (state_d == S_LOOP);
      pass_busy_d          = (state_d != S_IDLE);
      pass_done_d          = (state_d == S_DONE);
      pass_err_d           = (state_d == S_ERR);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q              <= S_IDLE;
         tile_idx_q           <= '0;
         wgt_cnt_q            <= '0;
         num_tiles_q          <= '0;
         tiles_per_wgt_q      <= '0;
         timeout_q            <= '0;
         wdog_q               <= '0;
         err_code_q           <= 2'd0;
         weight_load_state_q  <= 1'b0;
         init_fifo_pe_state_q <= 1'b0;
         preheat_state_q      <= 1'b0;
         normal_loop_state_q  <= 1'b0;
         pass_busy_q          <= 1'b0;
         pass_done_q          <= 1'b0;
         pass_err_q           <= 1'b0;
      end else begin
         state_q              <= state_d;
         tile_idx_q           <= tile_idx_d;
         wgt_cnt_q            <= wgt_cnt_d;
         num_tiles_q          <= num_tiles_d;
         tiles_per_wgt_q      <= tiles_per_wgt_d;
         timeout_q            <= timeout_d;
         wdog_q               <= wdog_d;
         err_code_q           <= err_code_d;
         weight_load_state_q  <= weight_load_state_d;
         init_fifo_pe_state_q <= init_fifo_pe_state_d;
         preheat_state_q      <= preheat_state_d;
         normal_loop_state_q  <= normal_loop_state_d;
         pass_busy_q          <= pass_busy_d;
         pass_done_q          <= pass_done_d;
         pass_err_q           <= pass_err_d;
      end
   end

   assign weight_load_state_o  = weight_load_state_q;
   assign init_fifo_pe_state_o = init_fifo_pe_state_q;
   assign preheat_state_o      = preheat_state_q;
   assign normal_loop_state_o  = normal_loop_state_q;
   assign tile_idx_o           = tile_idx_q;
   assign pass_busy_o          = pass_busy_q;
   assign pass_done_o          = pass_done_q;
   assign pass_err_o           = pass_err_q;
   assign err_code_o           = err_code_q;

endmodule

// File: tb/tb_pass_tile_sequencer.sv
// Scoreboard bench for pass_tile_sequencer: a pass-level model predicts every
// state visit (kind, tile, length, error code); a monitor compares observed visits.
module tb_pass_tile_sequencer;

   localparam int unsigned TILE_W = 8;
   localparam int unsigned TO_W   = 16;

   logic              clk;
   logic              rst_n;
   logic              pass_start_i;
   logic [TILE_W-1:0] cfg_num_tiles_i;
   logic [TILE_W-1:0] cfg_tiles_per_wgt_i;
   logic [TO_W-1:0]   cfg_timeout_i;
   logic              abort_i;
   logic              weight_load_done_i;
   logic              preheat_done_i;
   logic              normal_loop_done_i;
   logic              weight_load_state_o;
   logic              init_fifo_pe_state_o;
   logic              preheat_state_o;
   logic              normal_loop_state_o;
   logic [TILE_W-1:0] tile_idx_o;
   logic              pass_busy_o;
   logic              pass_done_o;
   logic              pass_err_o;
   logic [1:0]        err_code_o;

   pass_tile_sequencer #(.TILE_W(TILE_W), .TO_W(TO_W)) dut (
      .clk                  (clk),
      .rst_n                (rst_n),
      .pass_start_i         (pass_start_i),
      .cfg_num_tiles_i      (cfg_num_tiles_i),
      .cfg_tiles_per_wgt_i  (cfg_tiles_per_wgt_i),
      .cfg_timeout_i        (cfg_timeout_i),
      .abort_i              (abort_i),
      .weight_load_done_i   (weight_load_done_i),
      .preheat_done_i       (preheat_done_i),
      .normal_loop_done_i   (normal_loop_done_i),
      .weight_load_state_o  (weight_load_state_o),
      .init_fifo_pe_state_o (init_fifo_pe_state_o),
      .preheat_state_o      (preheat_state_o),
      .normal_loop_state_o  (normal_loop_state_o),
      .tile_idx_o           (tile_idx_o),
      .pass_busy_o          (pass_busy_o),
      .pass_done_o          (pass_done_o),
      .pass_err_o           (pass_err_o),
      .err_code_o           (err_code_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Visit kinds: 1 weight, 2 fifo/pe, 3 preheat, 4 loop, 5 done, 6 err, 7 illegal
   typedef struct {
      int kind;
      int tile;
      int len;
      int code;
   } rec_t;

   rec_t exp_q[$];
   int   lat[256];
   int   checks;
   int   errors;
   bit   mon_en;

   function automatic int cur_kind();
      int n;
      n = int'(weight_load_state_o) + int'(init_fifo_pe_state_o) + int'(preheat_state_o)
        + int'(normal_loop_state_o) + int'(pass_done_o) + int'(pass_err_o);
      if (n > 1) return 7;
      if (weight_load_state_o)  return 1;
      if (init_fifo_pe_state_o) return 2;
      if (preheat_state_o)      return 3;
      if (normal_loop_state_o)  return 4;
      if (pass_done_o)          return 5;
      if (pass_err_o)           return 6;
      return 0;
   endfunction

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   task automatic push(input int k, input int ti, input int l, input int c);
      rec_t r;
      r.kind = k; r.tile = ti; r.len = l; r.code = c;
      exp_q.push_back(r);
   endtask

   // Pass-level reference: lat[i] is the cycle of the i-th timed visit on which
   // its done arrives (0 = never); abort_cyc counts cycles after the start cycle.
   task automatic model_pass(input int t, input int p, input int to, input int abort_cyc,
                             output int fin_tile, output int fin_code);
      int cyc = 1, ti = 0, wc = 0, vi = 0, ph = 1, dur, l;
      bit to_err, fin = 0;
      fin_code = 0;
      if (t == 0) begin
         push(5, 0, 1, 0);
         fin_tile = 0;
         return;
      end
      while (!fin) begin
         to_err = 0;
         if (ph == 2) dur = 1;
         else begin
            l = lat[vi]; vi++;
            if (to != 0 && (l == 0 || l > to)) begin dur = to; to_err = 1; end
            else dur = l;
         end
         if (abort_cyc != 0 && abort_cyc >= cyc && abort_cyc < cyc + dur) begin
            push(ph, ti, abort_cyc - cyc + 1, 0);
            push(6, ti, 1, 0);
            fin_code = 0;
            fin = 1;
         end else begin
            push(ph, ti, dur, 0);
            cyc += dur;
            if (to_err) begin
               fin_code = (ph == 1) ? 1 : (ph == 3) ? 2 : 3;
               push(6, ti, 1, fin_code);
               fin = 1;
            end else begin
               case (ph)
                  1: ph = 2;
                  2: ph = 3;
                  3: ph = 4;
                  default: begin
                     if (ti == t - 1) begin
                        push(5, ti, 1, 0);
                        fin = 1;
                     end else begin
                        ti++;
                        if (p != 0 && wc == p - 1) begin wc = 0; ph = 1; end
                        else begin wc++; ph = 2; end
                     end
                  end
               endcase
            end
         end
      end
      fin_tile = ti;
   endtask

   // Groups consecutive cycles of one visit and scores it against the model
   task automatic monitor_loop();
      rec_t cur, e;
      bit   have = 0, busy_ok = 0;
      int   k;
      forever begin
         @(negedge clk);
         if (!mon_en) begin
            have = 0;
         end else begin
            k = cur_kind();
            if (have && k == cur.kind) begin
               cur.len++;
               busy_ok &= pass_busy_o;
            end else begin
               if (have) begin
                  checks++;
                  if (exp_q.size() == 0) begin
                     errors++;
                     $display("FAIL visit unexpected actual kind=%0d tile=%0d len=%0d required none",
                              cur.kind, cur.tile, cur.len);
                  end else begin
                     e = exp_q.pop_front();
                     if (cur.kind != e.kind || cur.tile != e.tile || cur.len != e.len ||
                         cur.code != e.code || !busy_ok) begin
                        errors++;
                        $display("FAIL visit actual kind=%0d tile=%0d len=%0d code=%0d busy=%0d required kind=%0d tile=%0d len=%0d code=%0d busy=1",
                                 cur.kind, cur.tile, cur.len, cur.code, busy_ok,
                                 e.kind, e.tile, e.len, e.code);
                     end
                  end
               end
               have = (k != 0);
               if (k != 0) begin
                  cur.kind = k;
                  cur.tile = int'(tile_idx_o);
                  cur.len  = 1;
                  cur.code = (k == 6) ? int'(err_code_o) : 0;
                  busy_ok  = pass_busy_o;
               end
            end
         end
      end
   endtask

   task automatic gen_lat(input int to);
      for (int i = 0; i < 256; i++)
         lat[i] = (to == 0) ? int'($urandom_range(1, 8)) : int'($urandom_range(0, to + 3));
   endtask

   // Drives one pass: L2 done responder, noise on unrelated done inputs,
   // spurious start pulses and cfg churn mid-pass, optional abort.
   task automatic run_pass(input int t, input int p, input int to, input int abort_cyc);
      int ft, fc, pc, k, pk, vcnt, rl, rvi;
      model_pass(t, p, to, abort_cyc, ft, fc);
      @(negedge clk);
      pass_start_i        = 1'b1;
      cfg_num_tiles_i     = TILE_W'(t);
      cfg_tiles_per_wgt_i = TILE_W'(p);
      cfg_timeout_i       = TO_W'(to);
      pc = 0; pk = 0; vcnt = 0; rl = 0; rvi = 0;
      while (1) begin
         @(negedge clk);
         pc++;
         k = cur_kind();
         pass_start_i        = 1'b0;
         abort_i             = 1'b0;
         weight_load_done_i  = 1'b0;
         preheat_done_i      = 1'b0;
         normal_loop_done_i  = 1'b0;
         cfg_num_tiles_i     = TILE_W'($urandom);
         cfg_tiles_per_wgt_i = TILE_W'($urandom);
         cfg_timeout_i       = TO_W'($urandom);
         if (k == 0 || pc > 2000) break;
         if ((k == 1 || k == 3 || k == 4) && k != pk) begin
            vcnt = 1; rl = lat[rvi]; rvi++;
         end else vcnt++;
         pk = k;
         weight_load_done_i = ($urandom % 4 == 0);
         preheat_done_i     = ($urandom % 4 == 0);
         normal_loop_done_i = ($urandom % 4 == 0);
         if (k == 1) weight_load_done_i = (rl != 0 && vcnt == rl);
         if (k == 3) preheat_done_i     = (rl != 0 && vcnt == rl);
         if (k == 4) normal_loop_done_i = (rl != 0 && vcnt == rl);
         if (k >= 1 && k <= 4) begin
            pass_start_i = ($urandom % 4 == 0);
            abort_i      = (pc == abort_cyc);
         end
      end
      weight_load_done_i  = 1'b0;
      preheat_done_i      = 1'b0;
      normal_loop_done_i  = 1'b0;
      cfg_num_tiles_i     = '0;
      cfg_tiles_per_wgt_i = '0;
      cfg_timeout_i       = '0;
      check("pass_cycle_budget", int'(pc > 2000), 0);
      repeat (2) @(negedge clk);
      check("visits_left", exp_q.size(), 0);
      exp_q.delete();
      check("idle_tile_idx", int'(tile_idx_o), ft);
      check("idle_err_code", int'(err_code_o), fc);
      check("idle_busy", int'(pass_busy_o), 0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL global_time_limit actual=expired required=finish");
      $fatal(1);
   end

   initial begin
      int t, p, to, a;
      checks = 0; errors = 0; mon_en = 0;
      rst_n = 1'b0;
      pass_start_i = 1'b0; abort_i = 1'b0;
      cfg_num_tiles_i = '0; cfg_tiles_per_wgt_i = '0; cfg_timeout_i = '0;
      weight_load_done_i = 1'b0; preheat_done_i = 1'b0; normal_loop_done_i = 1'b0;
      fork
         monitor_loop();
      join_none
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_kind", cur_kind(), 0);
      check("rst_busy", int'(pass_busy_o), 0);
      check("rst_tile_idx", int'(tile_idx_o), 0);
      check("rst_err_code", int'(err_code_o), 0);
      mon_en = 1;

      // Single tile, every done on the first cycle of its state
      for (int i = 0; i < 256; i++) lat[i] = 1;
      run_pass(1, 0, 0, 0);
      // Four tiles, weight reload every two tiles
      gen_lat(0);
      run_pass(4, 2, 0, 0);
      // Zero tiles: straight to done
      run_pass(0, 0, 0, 0);
      // Preheat never completes under an 8-cycle watchdog
      for (int i = 0; i < 256; i++) lat[i] = 0;
      lat[0] = 1;
      run_pass(2, 0, 8, 0);
      // Abort together with loop done in tile 1
      for (int i = 0; i < 256; i++) lat[i] = 1;
      run_pass(3, 0, 0, 7);
      // Weight done on the very last cycle before a 5-cycle timeout
      for (int i = 0; i < 256; i++) lat[i] = 2;
      lat[0] = 5;
      run_pass(1, 0, 5, 0);

      for (int n = 0; n < 40; n++) begin
         t  = int'($urandom_range(0, 6));
         p  = int'($urandom_range(0, 3));
         to = ($urandom % 2 == 0) ? 0 : int'($urandom_range(1, 12));
         a  = ($urandom % 4 == 0) ? int'($urandom_range(1, 60)) : 0;
         gen_lat(to);
         run_pass(t, p, to, a);
      end

      // Asynchronous reset in the middle of a pass
      mon_en = 0;
      @(negedge clk);
      pass_start_i = 1'b1;
      cfg_num_tiles_i = TILE_W'(3);
      cfg_timeout_i = '0;
      @(negedge clk);
      pass_start_i = 1'b0;
      @(negedge clk);
      check("pre_reset_busy", int'(pass_busy_o), 1);
      check("pre_reset_weight_state", int'(weight_load_state_o), 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_reset_busy", int'(pass_busy_o), 0);
      check("async_reset_kind", cur_kind(), 0);
      check("async_reset_tile_idx", int'(tile_idx_o), 0);
      check("async_reset_err_code", int'(err_code_o), 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check("post_reset_kind", cur_kind(), 0);
      mon_en = 1;
      gen_lat(6);
      run_pass(3, 1, 6, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
